// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension unit: extension modes,
// default widths and the skid-buffer state encoding.
package imm_ext_pkg;

    localparam int IMM_IN_W_DEF  = 16;
    localparam int IMM_OUT_W_DEF = 32;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'd0,
        MODE_ZERO   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } imm_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_extend_unit_if.sv
// Request/result handshake bundle of imm_extend_unit; the unit itself uses
// the slave modport, the producer/consumer side uses master.
interface imm_extend_unit_if
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W_DEF,
    parameter int OUT_W = IMM_OUT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/imm_ext_skid.sv
// Result buffer for imm_extend_unit. Define IMM_EXTEND_SKID_EN for a 2-entry
// skid buffer with registered in_ready; default is a single output register.
module imm_ext_skid
    import imm_ext_pkg::*;
#(
    parameter int OUT_W = IMM_OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

`ifdef IMM_EXTEND_SKID_EN

    skid_state_e      state_reg, state_next;
    logic [OUT_W-1:0] head_reg, tail_reg;
    logic             ready_reg;
    logic             accept, drain;

    assign accept = in_valid && ready_reg && !flush;
    assign drain  = (state_reg != ST_EMPTY) && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_EMPTY;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (accept) state_next = ST_ONE;
                ST_ONE: begin
                    if (accept && !drain)      state_next = ST_TWO;
                    else if (!accept && drain) state_next = ST_EMPTY;
                end
                ST_TWO:   if (drain) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_reg != ST_EMPTY);
        in_ready  = ready_reg;
        out_data  = head_reg;
    end

    // Held low through reset so the first acceptance is one cycle after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ready_reg <= 1'b0;
        else       ready_reg <= (state_next != ST_TWO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else if (!flush) begin
            case (state_reg)
                ST_EMPTY: if (accept) head_reg <= in_data;
                ST_ONE: begin
                    if (accept && drain) head_reg <= in_data;
                    else if (accept)     tail_reg <= in_data;
                end
                ST_TWO:   if (drain) head_reg <= tail_reg;
                default: ;
            endcase
        end
    end

`else

    logic             valid_reg;
    logic             ready_en_reg;
    logic [OUT_W-1:0] data_reg;
    logic             accept;

    // Combinational pass-through of out_ready keeps full throughput with one register.
    assign in_ready  = ready_en_reg && (!valid_reg || out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg    <= 1'b0;
            ready_en_reg <= 1'b0;
            data_reg     <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (flush) begin
                valid_reg <= 1'b0;
            end else if (accept) begin
                valid_reg <= 1'b1;
                data_reg  <= in_data;
            end else if (out_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

`endif

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate extension (sign / zero / upper / branch) feeding a result buffer.
// Define IMM_EXTEND_SKID_EN to select the 2-entry skid buffer in imm_ext_skid.
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W_DEF,
    parameter int OUT_W = IMM_OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    imm_extend_unit_if.slave bus
);

    logic [OUT_W-1:0] sign_ext, zero_ext, upper_ext, branch_ext, ext_data;

    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_extend_unit: OUT_W must be at least IN_W+2");
    end

    genvar gi;
    for (gi = 0; gi < OUT_W; gi++) begin : g_ext
        if (gi < IN_W) begin : g_low
            assign sign_ext[gi] = bus.in_imm[gi];
            assign zero_ext[gi] = bus.in_imm[gi];
        end else begin : g_high
            assign sign_ext[gi] = bus.in_imm[IN_W-1];
            assign zero_ext[gi] = 1'b0;
        end

        if (gi < OUT_W - IN_W) begin : g_upper_zero
            assign upper_ext[gi] = 1'b0;
        end else begin : g_upper_imm
            assign upper_ext[gi] = bus.in_imm[gi-(OUT_W-IN_W)];
        end

        // Branch offsets are word-aligned: sign-extended value shifted left by 2.
        if (gi < 2) begin : g_branch_zero
            assign branch_ext[gi] = 1'b0;
        end else begin : g_branch_shift
            assign branch_ext[gi] = sign_ext[gi-2];
        end
    end

    always_comb begin
        ext_data = sign_ext;
        case (imm_mode_e'(bus.in_mode))
            MODE_SIGN:   ext_data = sign_ext;
            MODE_ZERO:   ext_data = zero_ext;
            MODE_UPPER:  ext_data = upper_ext;
            MODE_BRANCH: ext_data = branch_ext;
            default:     ext_data = sign_ext;
        endcase
    end

    imm_ext_skid #(
        .OUT_W(OUT_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .in_data  (ext_data),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .out_data (bus.out_data)
    );

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: vector table, backpressure, flush,
// mid-stream reset and randomized traffic against a queue-based reference.
module tb_imm_extend_unit;
    import imm_ext_pkg::*;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
`ifdef IMM_EXTEND_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic flush;

    imm_extend_unit_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] seen_q[$];
    bit ready_ok = 1'b0;

    logic             ir, ov;
    logic [OUT_W-1:0] od;

    typedef struct {
        logic [1:0]       mode;
        logic [IN_W-1:0]  imm;
        logic [OUT_W-1:0] exp;
    } vec_t;
    vec_t vecs[10];

    // Reference extension computed arithmetically on integers.
    function automatic logic [OUT_W-1:0] ref_ext(input int mode, input longint imm);
        longint sval, res;
        logic [63:0] bits;
        sval = (imm >= (longint'(1) << (IN_W-1))) ? imm - (longint'(1) << IN_W) : imm;
        case (mode)
            0:       res = sval;
            1:       res = imm;
            2:       res = imm * (longint'(1) << (OUT_W-IN_W));
            default: res = sval * 4;
        endcase
        bits = res;
        return bits[OUT_W-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, sample at negedge against the model, update model after the edge.
    task automatic cycle(input bit v, input logic [1:0] m, input logic [IN_W-1:0] imm,
                         input bit ordy, input bit fl,
                         output logic s_ir, output logic s_ov, output logic [OUT_W-1:0] s_od);
        bit exp_ready, acc, drn;
        bus.in_valid  = v;
        bus.in_mode   = m;
        bus.in_imm    = imm;
        bus.out_ready = ordy;
        flush         = fl;
        @(negedge clk);
        if (SKID) exp_ready = ready_ok && (exp_q.size() < 2);
        else      exp_ready = ready_ok && (exp_q.size() == 0 || ordy);
        s_ir = bus.in_ready;
        s_ov = bus.out_valid;
        s_od = bus.out_data;
        check("in_ready", s_ir, exp_ready);
        check("out_valid", s_ov, exp_q.size() != 0);
        if (exp_q.size() != 0) check("out_data", s_od, exp_q[0]);
        acc = v && exp_ready && !fl;
        drn = (exp_q.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (drn) begin
            seen_q.push_back(s_od);
            $display("xfer data=0x%h t=%0t", s_od, $time);
        end
        if (fl) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(ref_ext(int'(m), longint'(imm)));
        end
        if (!reset) ready_ok = 1'b1;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 2'd0, '0, ordy, 1'b0, ir, ov, od);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit has_ff;
        vecs[0] = '{MODE_SIGN,   16'h8001, 32'hFFFF8001};
        vecs[1] = '{MODE_ZERO,   16'h8001, 32'h00008001};
        vecs[2] = '{MODE_UPPER,  16'h1234, 32'h12340000};
        vecs[3] = '{MODE_BRANCH, 16'hFFFF, 32'hFFFFFFFC};
        vecs[4] = '{MODE_SIGN,   16'h7FFF, 32'h00007FFF};
        vecs[5] = '{MODE_ZERO,   16'hFFFF, 32'h0000FFFF};
        vecs[6] = '{MODE_UPPER,  16'hFFFF, 32'hFFFF0000};
        vecs[7] = '{MODE_BRANCH, 16'h0001, 32'h00000004};
        vecs[8] = '{MODE_BRANCH, 16'h8000, 32'hFFFE0000};
        vecs[9] = '{MODE_BRANCH, 16'h4000, 32'h00010000};

        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_imm = '0;
        bus.in_mode = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1'b1);
        check("rdy_not_early", ir, 0);

        // Table vectors: accept, then expect the result one cycle later.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, vecs[i].mode, vecs[i].imm, 1'b1, 1'b0, ir, ov, od);
            check("vec_accept", ir, 1);
            idle(1'b1);
            check("vec_valid", ov, 1);
            check("vec_data", od, vecs[i].exp);
        end

        // Back-to-back throughput with out_ready held high.
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, MODE_ZERO, IN_W'(16'h0010 + k), 1'b1, 1'b0, ir, ov, od);
            check("tput_ready", ir, 1);
            if (k > 0) begin
                check("tput_valid", ov, 1);
                check("tput_data", od, OUT_W'(32'h0010 + k - 1));
            end
        end
        idle(1'b1);

        // Backpressure: out_ready low for three cycles while offering 1,2,3.
        seen_q.delete();
`ifdef IMM_EXTEND_SKID_EN
        cycle(1'b1, MODE_ZERO, 16'h0001, 1'b0, 1'b0, ir, ov, od); check("bp_acc1", ir, 1);
        cycle(1'b1, MODE_ZERO, 16'h0002, 1'b0, 1'b0, ir, ov, od); check("bp_acc2", ir, 1);
        cycle(1'b1, MODE_ZERO, 16'h0003, 1'b0, 1'b0, ir, ov, od); check("bp_full", ir, 0);
        cycle(1'b1, MODE_ZERO, 16'h0003, 1'b1, 1'b0, ir, ov, od); check("bp_full_drain", ir, 0);
        cycle(1'b1, MODE_ZERO, 16'h0003, 1'b1, 1'b0, ir, ov, od); check("bp_acc3", ir, 1);
`else
        cycle(1'b1, MODE_ZERO, 16'h0001, 1'b0, 1'b0, ir, ov, od); check("bp_acc1", ir, 1);
        cycle(1'b1, MODE_ZERO, 16'h0002, 1'b0, 1'b0, ir, ov, od); check("bp_full", ir, 0);
        cycle(1'b1, MODE_ZERO, 16'h0002, 1'b0, 1'b0, ir, ov, od); check("bp_full2", ir, 0);
        cycle(1'b1, MODE_ZERO, 16'h0002, 1'b1, 1'b0, ir, ov, od); check("bp_acc2", ir, 1);
        cycle(1'b1, MODE_ZERO, 16'h0003, 1'b1, 1'b0, ir, ov, od); check("bp_acc3", ir, 1);
`endif
        idle(1'b1);
        idle(1'b1);
        check("bp_count", seen_q.size(), 3);
        for (int i = 0; i < 3 && i < seen_q.size(); i++) check("bp_order", seen_q[i], i + 1);

        // Flush wins over a simultaneous request.
        seen_q.delete();
        cycle(1'b1, MODE_ZERO, 16'h0011, 1'b0, 1'b0, ir, ov, od);
        cycle(1'b1, MODE_ZERO, 16'h00FF, 1'b1, 1'b1, ir, ov, od);
        idle(1'b1);
        check("flush_valid", ov, 0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        has_ff = 1'b0;
        foreach (seen_q[i]) if (seen_q[i] == 32'h000000FF) has_ff = 1'b1;
        check("flush_discard", has_ff, 0);

        // Reset in the middle of a stream with results buffered.
        cycle(1'b1, MODE_ZERO, 16'h0021, 1'b0, 1'b0, ir, ov, od);
        cycle(1'b1, MODE_ZERO, 16'h0022, 1'b0, 1'b0, ir, ov, od);
        #2;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("rst_mid_valid", bus.out_valid, 0);
        check("rst_mid_data", bus.out_data, 0);
        check("rst_mid_ready", bus.in_ready, 0);
        exp_q.delete();
        ready_ok = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b1, MODE_SIGN, 16'h0005, 1'b1, 1'b0, ir, ov, od);
        check("rst_rdy_not_early", ir, 0);
        check("rst_no_stale", ov, 0);
        cycle(1'b1, MODE_SIGN, 16'h0005, 1'b1, 1'b0, ir, ov, od);
        check("rst_rdy_after", ir, 1);
        idle(1'b1);
        check("rst_first_data", od, 32'h00000005);

        // Randomized traffic against the reference queue.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), IN_W'($urandom),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, ir, ov, od);
        end
        for (int n = 0; n < 4; n++) idle(1'b1);
        check("final_empty", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
